// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS core: opcode/funct values,
// FSM state encoding, ALU operation codes and small decode/ALU helpers.
package mips_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned REG_AW  = 5;
  localparam int unsigned NUM_REG = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_t;

  // R-type funct to ALU operation; unknown functs never reach EXECUTE.
  function automatic alu_op_t funct_to_alu(input logic [5:0] funct);
    alu_op_t op;
    op = ALU_ADD;
    case (funct)
      FN_SUB:  op = ALU_SUB;
      FN_AND:  op = ALU_AND;
      FN_OR:   op = ALU_OR;
      FN_SLT:  op = ALU_SLT;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  function automatic logic [XLEN-1:0] alu_eval(input alu_op_t op,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    logic [XLEN-1:0] r;
    r = '0;
    case (op)
      ALU_ADD: r = a + b;
      ALU_SUB: r = a - b;
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_SLT: r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic is_legal(input logic [5:0] opcode,
                                    input logic [5:0] funct,
                                    input logic       enable_jump);
    logic ok;
    ok = 1'b0;
    case (opcode)
      OP_RTYPE: ok = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                     (funct == FN_OR)  || (funct == FN_SLT);
      OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE: ok = 1'b1;
      OP_J:     ok = enable_jump;
      default:  ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// 32x32 register file: two asynchronous read ports, one synchronous write
// port, register 0 hardwired to zero, asynchronous active-low clear.
//   clk, rst_n        : clock, async active-low clear of all registers
//   raddr_a/rdata_a   : read port A
//   raddr_b/rdata_b   : read port B
//   we/waddr/wdata    : write port (writes to register 0 are dropped)
module regfile_2r1w
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] raddr_a,
  output logic [XLEN-1:0]   rdata_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [XLEN-1:0]   rdata_b,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [XLEN-1:0]   wdata
);

  logic [XLEN-1:0] regs [NUM_REG];

  // Storage with async clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_REG); i++) regs[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == '0) ? '0 : regs[raddr_a];
  assign rdata_b = (raddr_b == '0) ? '0 : regs[raddr_b];

endmodule

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS core with one shared instruction/data memory port
// (req/ready handshake), halting on illegal instructions and misaligned
// data accesses, and a retired-instruction counter.
//   clock, reset          : rising-edge clock, async active-low reset
//   mem_req/we/addr/wdata : registered memory request, held until mem_ready
//   mem_rdata, mem_ready  : memory response
//   pc, halted            : current PC, sticky halt flag
//   retired_count         : completed instruction count (wraps)
module mips_multicycle_core
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned CNT_WIDTH   = 32,
  parameter bit          ENABLE_JUMP = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [XLEN-1:0]      mem_addr,
  output logic [XLEN-1:0]      mem_wdata,
  input  logic [XLEN-1:0]      mem_rdata,
  input  logic                 mem_ready,
  output logic [XLEN-1:0]      pc,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] retired_count
);

  state_t          state, state_nx;
  logic [XLEN-1:0] ir, a, b, target, alu_out, mdr;
  logic [XLEN-1:0] ir_nx, a_nx, b_nx, target_nx, alu_out_nx, mdr_nx, pc_nx;
  logic [XLEN-1:0] addr_nx, wdata_nx;
  logic            req_nx, we_nx, halted_nx;
  logic [CNT_WIDTH-1:0] count_nx;
  logic            retire, trap;

  logic [5:0]        opcode, funct;
  logic [REG_AW-1:0] rs, rt, rd;
  logic [XLEN-1:0]   imm_sext, rf_a, rf_b, alu_b, alu_res;
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [XLEN-1:0]   rf_wdata;

  assign opcode   = ir[31:26];
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign funct    = ir[5:0];
  assign imm_sext = {{16{ir[15]}}, ir[15:0]};

  // Shared ALU: R-type uses funct and B, everything else adds the immediate.
  assign alu_b   = (opcode == OP_RTYPE) ? b : imm_sext;
  assign alu_res = alu_eval((opcode == OP_RTYPE) ? funct_to_alu(funct) : ALU_ADD, a, alu_b);

  assign rf_we    = (state == S_WRITEBACK);
  assign rf_waddr = (opcode == OP_RTYPE) ? rd : rt;
  assign rf_wdata = (opcode == OP_LW) ? mdr : alu_out;

  regfile_2r1w u_rf (
    .clk     (clock),
    .rst_n   (reset),
    .raddr_a (rs),
    .rdata_a (rf_a),
    .raddr_b (rt),
    .rdata_b (rf_b),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata)
  );

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= S_FETCH;
      pc            <= RESET_PC;
      ir            <= '0;
      a             <= '0;
      b             <= '0;
      target        <= '0;
      alu_out       <= '0;
      mdr           <= '0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      halted        <= 1'b0;
      retired_count <= '0;
    end else begin
      state         <= state_nx;
      pc            <= pc_nx;
      ir            <= ir_nx;
      a             <= a_nx;
      b             <= b_nx;
      target        <= target_nx;
      alu_out       <= alu_out_nx;
      mdr           <= mdr_nx;
      mem_req       <= req_nx;
      mem_we        <= we_nx;
      mem_addr      <= addr_nx;
      mem_wdata     <= wdata_nx;
      halted        <= halted_nx;
      retired_count <= count_nx;
    end
  end

  // Next-state and next-register logic. Memory request registers are loaded
  // on entry to FETCH/MEMORY so the request is visible in that state.
  always_comb begin
    state_nx   = state;
    pc_nx      = pc;
    ir_nx      = ir;
    a_nx       = a;
    b_nx       = b;
    target_nx  = target;
    alu_out_nx = alu_out;
    mdr_nx     = mdr;
    req_nx     = mem_req;
    we_nx      = mem_we;
    addr_nx    = mem_addr;
    wdata_nx   = mem_wdata;
    halted_nx  = halted;
    count_nx   = retired_count;
    retire     = 1'b0;
    trap       = 1'b0;

    unique case (state)
      S_FETCH: begin
        if (!mem_req) begin
          // Only reached right after reset: launch the first fetch.
          req_nx  = 1'b1;
          we_nx   = 1'b0;
          addr_nx = pc;
        end else if (mem_ready) begin
          ir_nx    = mem_rdata;
          pc_nx    = pc + XLEN'(4);
          req_nx   = 1'b0;
          state_nx = S_DECODE;
        end
      end
      S_DECODE: begin
        a_nx      = rf_a;
        b_nx      = rf_b;
        target_nx = pc + {imm_sext[XLEN-3:0], 2'b00};
        if (!is_legal(opcode, funct, ENABLE_JUMP)) trap = 1'b1;
        else state_nx = S_EXECUTE;
      end
      S_EXECUTE: begin
        case (opcode)
          OP_RTYPE, OP_ADDI: begin
            alu_out_nx = alu_res;
            state_nx   = S_WRITEBACK;
          end
          OP_LW, OP_SW: begin
            alu_out_nx = alu_res;
            if (alu_res[1:0] != 2'b00) begin
              trap = 1'b1;
            end else begin
              req_nx   = 1'b1;
              we_nx    = (opcode == OP_SW);
              addr_nx  = alu_res;
              wdata_nx = b;
              state_nx = S_MEMORY;
            end
          end
          OP_BEQ: begin
            if (a == b) pc_nx = target;
            retire = 1'b1;
          end
          OP_BNE: begin
            if (a != b) pc_nx = target;
            retire = 1'b1;
          end
          OP_J: begin
            pc_nx  = {pc[31:28], ir[25:0], 2'b00};
            retire = 1'b1;
          end
          default: trap = 1'b1;
        endcase
      end
      S_MEMORY: begin
        if (mem_ready) begin
          req_nx = 1'b0;
          we_nx  = 1'b0;
          if (mem_we) begin
            retire = 1'b1;
          end else begin
            mdr_nx   = mem_rdata;
            state_nx = S_WRITEBACK;
          end
        end
      end
      S_WRITEBACK: retire = 1'b1;
      S_HALT: req_nx = 1'b0;
      default: trap = 1'b1;
    endcase

    // Retire: count and launch the next fetch from the updated PC.
    if (retire) begin
      state_nx = S_FETCH;
      req_nx   = 1'b1;
      we_nx    = 1'b0;
      addr_nx  = pc_nx;
      count_nx = retired_count + CNT_WIDTH'(1);
    end

    if (trap) begin
      state_nx  = S_HALT;
      halted_nx = 1'b1;
      req_nx    = 1'b0;
      we_nx     = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed testbench for mips_multicycle_core with a 1 KB word memory model.
module tb_mips_multicycle_core;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_req, mem_we, mem_ready, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc, retired_count;

  logic        nj_req, nj_we, nj_halted;
  logic [31:0] nj_addr, nj_wdata, nj_pc, nj_rdata;
  logic [7:0]  nj_count;

  logic [31:0] mem [256];
  logic        clear_en = 1'b0, load_en = 1'b0;
  logic [7:0]  load_idx = '0;
  logic [31:0] load_data = '0;
  int          stall_cycles = 0;
  int          stall_used;
  logic [31:0] prog [$];

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  mips_multicycle_core #(.RESET_PC(32'h100), .CNT_WIDTH(32), .ENABLE_JUMP(1'b1)) dut (
    .clock(clock), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .pc(pc), .halted(halted), .retired_count(retired_count)
  );

  // Jump-disabled core whose memory always returns "j 0x40".
  assign nj_rdata = 32'h0800_0010;
  mips_multicycle_core #(.RESET_PC(32'h0), .CNT_WIDTH(8), .ENABLE_JUMP(1'b0)) dut_nj (
    .clock(clock), .reset(reset), .mem_req(nj_req), .mem_we(nj_we),
    .mem_addr(nj_addr), .mem_wdata(nj_wdata), .mem_rdata(nj_rdata),
    .mem_ready(1'b1), .pc(nj_pc), .halted(nj_halted), .retired_count(nj_count)
  );

  // Memory model: stores to address 8 are held off for stall_cycles cycles.
  assign mem_rdata = mem[mem_addr[9:2]];
  assign mem_ready = !(mem_req && mem_we && (mem_addr == 32'h8) && (stall_used < stall_cycles));

  always @(posedge clock) begin
    if (clear_en) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hFC00_0000;
      stall_used <= 0;
    end else if (load_en) begin
      mem[load_idx] <= load_data;
    end else begin
      if (mem_req && mem_ready && mem_we) mem[mem_addr[9:2]] <= mem_wdata;
      if (mem_req && !mem_ready) stall_used <= stall_used + 1;
    end
  end

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] enc_j(input logic [25:0] idx);
    return {6'h02, idx};
  endfunction

  task automatic enter_reset();
    reset = 1'b0;
    stall_cycles = 0;
    clear_en = 1'b1;
    @(posedge clock);
    #1 clear_en = 1'b0;
  endtask

  task automatic load_word(input logic [31:0] addr, input logic [31:0] data);
    load_idx = addr[9:2];
    load_data = data;
    load_en = 1'b1;
    @(posedge clock);
    #1 load_en = 1'b0;
  endtask

  task automatic load_prog(input logic [31:0] base);
    foreach (prog[i]) load_word(base + 32'(i) * 32'd4, prog[i]);
  endtask

  task automatic release_reset();
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic wait_halt(input int bound);
    int n;
    n = 0;
    while (!halted && n < bound) begin
      @(negedge clock);
      n++;
    end
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_timeout got=%b exp=1", halted); end
  endtask

  task automatic test_reset();
    enter_reset();
    checks++; if (pc !== 32'h100) begin errors++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h100); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_we got=%b exp=0", mem_we); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata got=%h exp=0", mem_wdata); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got=%b exp=0", halted); end
    checks++; if (retired_count !== 32'h0) begin errors++; $display("FAIL reset_count got=%0d exp=0", retired_count); end
    prog = '{enc_i(6'h08, 0, 1, 5)};
    load_prog(32'h100);
    release_reset();
    @(negedge clock);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL first_req got=%b exp=1", mem_req); end
    checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL first_addr got=%h exp=%h", mem_addr, 32'h100); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL first_we got=%b exp=0", mem_we); end
    @(negedge clock);
    checks++; if (pc !== 32'h104) begin errors++; $display("FAIL pc_after_fetch got=%h exp=%h", pc, 32'h104); end
    checks++; if (retired_count !== 32'h0) begin errors++; $display("FAIL count_before_retire got=%0d exp=0", retired_count); end
    wait_halt(50);
    checks++; if (retired_count !== 32'd1) begin errors++; $display("FAIL count_one got=%0d exp=1", retired_count); end
  endtask

  task automatic test_arith();
    int k;
    enter_reset();
    prog = '{enc_i(6'h08, 0, 1, 5), enc_i(6'h08, 0, 2, -3),
             enc_r(1, 2, 3, 6'h20), enc_r(2, 1, 4, 6'h2A),
             enc_r(1, 2, 5, 6'h22), enc_r(1, 2, 6, 6'h24),
             enc_r(1, 2, 7, 6'h25), enc_r(1, 2, 8, 6'h2A),
             enc_i(6'h2B, 0, 3, 32'h20), enc_i(6'h2B, 0, 4, 32'h24),
             enc_i(6'h2B, 0, 5, 32'h28), enc_i(6'h2B, 0, 6, 32'h2C),
             enc_i(6'h2B, 0, 7, 32'h30), enc_i(6'h2B, 0, 8, 32'h34),
             enc_i(6'h08, 0, 0, 7), enc_i(6'h2B, 0, 0, 32'h38),
             32'hFC00_0000};
    load_prog(32'h100);
    load_word(32'h38, 32'hDEAD_BEEF);
    release_reset();
    @(negedge clock);
    k = 0;
    while (retired_count != 32'd4 && k < 40) begin
      @(negedge clock);
      k++;
    end
    checks++; if (k != 16) begin errors++; $display("FAIL arith_cycles got=%0d exp=16", k); end
    wait_halt(400);
    checks++; if (mem[8] !== 32'd2) begin errors++; $display("FAIL add got=%h exp=2", mem[8]); end
    checks++; if (mem[9] !== 32'd1) begin errors++; $display("FAIL slt_true got=%h exp=1", mem[9]); end
    checks++; if (mem[10] !== 32'd8) begin errors++; $display("FAIL sub got=%h exp=8", mem[10]); end
    checks++; if (mem[11] !== 32'd5) begin errors++; $display("FAIL and got=%h exp=5", mem[11]); end
    checks++; if (mem[12] !== 32'hFFFF_FFFD) begin errors++; $display("FAIL or got=%h exp=fffffffd", mem[12]); end
    checks++; if (mem[13] !== 32'd0) begin errors++; $display("FAIL slt_false got=%h exp=0", mem[13]); end
    checks++; if (mem[14] !== 32'd0) begin errors++; $display("FAIL reg0_write got=%h exp=0", mem[14]); end
    checks++; if (retired_count !== 32'd16) begin errors++; $display("FAIL arith_count got=%0d exp=16", retired_count); end
    checks++; if (pc !== 32'h144) begin errors++; $display("FAIL opcode3f_pc got=%h exp=%h", pc, 32'h144); end
    repeat (10) @(negedge clock);
    checks++; if (pc !== 32'h144) begin errors++; $display("FAIL frozen_pc got=%h exp=%h", pc, 32'h144); end
    checks++; if (retired_count !== 32'd16) begin errors++; $display("FAIL frozen_count got=%0d exp=16", retired_count); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL halt_req got=%b exp=0", mem_req); end
  endtask

  task automatic test_mem_stall();
    int held, k;
    enter_reset();
    prog = '{enc_i(6'h08, 0, 1, 5), enc_i(6'h2B, 0, 1, 8), enc_i(6'h23, 0, 5, 8),
             enc_i(6'h2B, 0, 5, 12), 32'hFC00_0000};
    load_prog(32'h100);
    stall_cycles = 3;
    release_reset();
    held = 0;
    k = 0;
    while (!halted && k < 300) begin
      @(negedge clock);
      k++;
      if (mem_req && mem_we && mem_addr == 32'h8 && mem_wdata == 32'd5) held++;
    end
    checks++; if (held != 4) begin errors++; $display("FAIL sw_held_cycles got=%0d exp=4", held); end
    wait_halt(10);
    checks++; if (mem[2] !== 32'd5) begin errors++; $display("FAIL sw_data got=%h exp=5", mem[2]); end
    checks++; if (mem[3] !== 32'd5) begin errors++; $display("FAIL lw_data got=%h exp=5", mem[3]); end
    checks++; if (retired_count !== 32'd4) begin errors++; $display("FAIL mem_count got=%0d exp=4", retired_count); end
  endtask

  task automatic test_branch_jump();
    logic [31:0] f_addr [16];
    int          f_cyc [16];
    logic [31:0] exp_addr [8];
    int          exp_gap [8];
    int nf, k;
    enter_reset();
    load_word(32'h100, enc_i(6'h08, 0, 1, 5));
    load_word(32'h104, enc_j(26'h0));
    load_word(32'h000, enc_i(6'h04, 1, 1, 2));
    load_word(32'h00C, enc_i(6'h05, 1, 1, 5));
    load_word(32'h010, enc_i(6'h05, 1, 0, 27));
    load_word(32'h080, enc_i(6'h04, 1, 0, 3));
    load_word(32'h084, enc_j(26'h42));
    release_reset();
    exp_addr = '{32'h100, 32'h104, 32'h000, 32'h00C, 32'h010, 32'h080, 32'h084, 32'h108};
    exp_gap  = '{0, 4, 3, 3, 3, 3, 3, 3};
    nf = 0;
    k = 0;
    while (!halted && k < 200) begin
      @(negedge clock);
      k++;
      if (mem_req && mem_ready && !mem_we && nf < 16) begin
        f_addr[nf] = mem_addr;
        f_cyc[nf] = k;
        nf++;
      end
    end
    checks++; if (nf != 8) begin errors++; $display("FAIL fetch_count got=%0d exp=8", nf); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (f_addr[i] !== exp_addr[i]) begin errors++; $display("FAIL fetch_addr[%0d] got=%h exp=%h", i, f_addr[i], exp_addr[i]); end
    end
    for (int i = 1; i < 8; i++) begin
      checks++; if (f_cyc[i] - f_cyc[i-1] != exp_gap[i]) begin errors++; $display("FAIL fetch_gap[%0d] got=%0d exp=%0d", i, f_cyc[i] - f_cyc[i-1], exp_gap[i]); end
    end
    wait_halt(10);
    checks++; if (retired_count !== 32'd7) begin errors++; $display("FAIL branch_count got=%0d exp=7", retired_count); end
    checks++; if (pc !== 32'h10C) begin errors++; $display("FAIL branch_pc got=%h exp=%h", pc, 32'h10C); end
  endtask

  task automatic test_traps();
    int bad, reqs, k;
    enter_reset();
    prog = '{enc_i(6'h23, 0, 2, 6)};
    load_prog(32'h100);
    release_reset();
    bad = 0; reqs = 0; k = 0;
    while (!halted && k < 100) begin
      @(negedge clock);
      k++;
      if (mem_req) reqs++;
      if (mem_req && mem_addr == 32'h6) bad++;
    end
    wait_halt(10);
    checks++; if (bad != 0) begin errors++; $display("FAIL misaligned_access got=%0d exp=0", bad); end
    checks++; if (reqs != 1) begin errors++; $display("FAIL misaligned_reqs got=%0d exp=1", reqs); end
    repeat (10) @(negedge clock);
    checks++; if (pc !== 32'h104) begin errors++; $display("FAIL misaligned_pc got=%h exp=%h", pc, 32'h104); end
    checks++; if (retired_count !== 32'd0) begin errors++; $display("FAIL misaligned_count got=%0d exp=0", retired_count); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL misaligned_req got=%b exp=0", mem_req); end
    checks++; if (nj_halted !== 1'b1) begin errors++; $display("FAIL nojump_halted got=%b exp=1", nj_halted); end
    checks++; if (nj_pc !== 32'h4) begin errors++; $display("FAIL nojump_pc got=%h exp=4", nj_pc); end
    checks++; if (nj_count !== 8'd0) begin errors++; $display("FAIL nojump_count got=%0d exp=0", nj_count); end
    checks++; if (nj_req !== 1'b0) begin errors++; $display("FAIL nojump_req got=%b exp=0", nj_req); end
    enter_reset();
    prog = '{enc_i(6'h08, 0, 1, 1), enc_r(0, 0, 0, 6'h00)};
    load_prog(32'h100);
    release_reset();
    wait_halt(100);
    checks++; if (retired_count !== 32'd1) begin errors++; $display("FAIL bad_funct_count got=%0d exp=1", retired_count); end
    checks++; if (pc !== 32'h108) begin errors++; $display("FAIL bad_funct_pc got=%h exp=%h", pc, 32'h108); end
  endtask

  task automatic test_async_reset();
    int k;
    enter_reset();
    prog = '{enc_i(6'h08, 0, 1, 5), enc_i(6'h2B, 0, 1, 8)};
    load_prog(32'h100);
    stall_cycles = 1000;
    release_reset();
    k = 0;
    while (!(mem_req && mem_we) && k < 40) begin
      @(negedge clock);
      k++;
    end
    checks++; if (!(mem_req && mem_we)) begin errors++; $display("FAIL stall_reach got=%b exp=1", mem_req && mem_we); end
    checks++; if (retired_count !== 32'd1) begin errors++; $display("FAIL pre_reset_count got=%0d exp=1", retired_count); end
    #2 reset = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL async_req got=%b exp=0", mem_req); end
    checks++; if (pc !== 32'h100) begin errors++; $display("FAIL async_pc got=%h exp=%h", pc, 32'h100); end
    checks++; if (retired_count !== 32'd0) begin errors++; $display("FAIL async_count got=%0d exp=0", retired_count); end
    enter_reset();
    prog = '{enc_i(6'h2B, 0, 1, 32'h10), enc_i(6'h08, 0, 0, 9), enc_i(6'h2B, 0, 0, 32'h14)};
    load_prog(32'h100);
    load_word(32'h10, 32'h1234);
    load_word(32'h14, 32'h5678);
    release_reset();
    wait_halt(200);
    checks++; if (mem[4] !== 32'd0) begin errors++; $display("FAIL reg_cleared got=%h exp=0", mem[4]); end
    checks++; if (mem[5] !== 32'd0) begin errors++; $display("FAIL reg0_after_reset got=%h exp=0", mem[5]); end
    checks++; if (retired_count !== 32'd3) begin errors++; $display("FAIL post_reset_count got=%0d exp=3", retired_count); end
    checks++; if (pc !== 32'h110) begin errors++; $display("FAIL post_reset_pc got=%h exp=%h", pc, 32'h110); end
  endtask

  initial begin
    reset = 1'b0;
    test_reset();
    test_arith();
    test_mem_stall();
    test_branch_jump();
    test_traps();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
